// File: rtl/l2bus_arbiter_if.sv
// L2 coherence bus bundle: per-agent request fields in, muxed slot signals out.
// master is the arbiter's view; slave is the agent/snooper side.
interface l2bus_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int NSNOOP = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*3-1:0]  req_cmd;
  logic [NREQ*5-1:0]  req_tag;
  logic [NREQ*26-1:0] req_addr;
  logic [NREQ*64-1:0] req_data;
  logic [NSNOOP-1:0]  nack_in;

  logic [NREQ-1:0]    grant;
  logic [2:0]         bus_cycle;
  logic               bus_valid;
  logic [IDW-1:0]     bus_owner;
  logic [2:0]         bus_cmd;
  logic [4:0]         bus_tag;
  logic [25:0]        bus_addr;
  logic [63:0]        bus_data;
  logic               bus_nack;

  modport master (
    input  req, req_cmd, req_tag, req_addr, req_data, nack_in,
    output grant, bus_cycle, bus_valid, bus_owner, bus_cmd, bus_tag,
           bus_addr, bus_data, bus_nack
  );

  modport slave (
    output req, req_cmd, req_tag, req_addr, req_data, nack_in,
    input  grant, bus_cycle, bus_valid, bus_owner, bus_cmd, bus_tag,
           bus_addr, bus_data, bus_nack
  );
endinterface

// File: rtl/l2bus_arbiter.sv
// L2 bus arbiter: free-running 8-cycle slot counter, round-robin grant in
// cycle 7 with nack retry priority, and owner field mux onto the shared bus.
module l2bus_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int NSNOOP = 4
) (
  input logic              clk,
  input logic              rst,
  l2bus_arbiter_if.master  bus
);

  logic [2:0]        cyc_q;
  logic              owner_valid_q;
  logic [IDW-1:0]    owner_q;
  logic [IDW-1:0]    rr_ptr_q;

  logic [NSNOOP-1:0] nack_votes;
  logic              any_req;
  logic              nack;
  logic [IDW-1:0]    base;
  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    idx;
  logic              found;
  logic [NREQ-1:0]   grant_d;
  logic [2:0]        cmd_d;
  logic [4:0]        tag_d;
  logic [25:0]       addr_d;
  logic [63:0]       data_d;

  assign nack_votes = bus.nack_in;
  assign any_req    = |bus.req;
  assign nack       = owner_valid_q & (|nack_votes);

  // A nacked owner restarts the scan at itself so its retry wins the next slot.
  always_comb begin
    base   = nack ? owner_q : rr_ptr_q;
    winner = base;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(base) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    if (cyc_q == 3'd7 && any_req) grant_d[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q         <= 3'd0;
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
    end else begin
      cyc_q <= cyc_q + 3'd1;
      if (cyc_q == 3'd7) begin
        owner_valid_q <= any_req;
        if (any_req) begin
          owner_q  <= winner;
          rr_ptr_q <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmd_d  = '0;
    tag_d  = '0;
    addr_d = '0;
    data_d = '0;
    if (owner_valid_q) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == IDW'(i)) begin
          cmd_d  = bus.req_cmd[i*3 +: 3];
          tag_d  = bus.req_tag[i*5 +: 5];
          addr_d = bus.req_addr[i*26 +: 26];
          data_d = bus.req_data[i*64 +: 64];
        end
      end
    end
  end

  assign bus.grant     = grant_d;
  assign bus.bus_cycle = cyc_q;
  assign bus.bus_valid = owner_valid_q;
  assign bus.bus_owner = owner_q;
  assign bus.bus_cmd   = cmd_d;
  assign bus.bus_tag   = tag_d;
  assign bus.bus_addr  = addr_d;
  assign bus.bus_data  = data_d;
  assign bus.bus_nack  = nack;

endmodule

// File: tb/tb_l2bus_arbiter.sv
// Bench for l2bus_arbiter: directed scenarios plus random traffic, compared
// against a slot-level reference model of the arbitration rules.
module tb_l2bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2bus_arbiter_if #(.NREQ(4), .IDW(2), .NSNOOP(4)) l2 ();
  l2bus_arbiter #(.NREQ(4), .IDW(2), .NSNOOP(4)) dut (.clk(clk), .rst(rst), .bus(l2));

  int vectors = 0;
  int miscompares = 0;

  logic [2:0]  cmd_a  [4];
  logic [4:0]  tag_a  [4];
  logic [25:0] addr_a [4];
  logic [63:0] data_a [4];

  // Reference model: slot phase, current owner, and next round-robin start.
  logic [2:0] m_cycle;
  logic       m_valid;
  logic [1:0] m_owner;
  logic [1:0] m_rr;

  typedef logic [108:0] vec_t;

  function automatic logic [1:0] pick(logic [3:0] r, logic [1:0] start);
    logic [1:0] i;
    i = start;
    repeat (4) begin
      if (r[i]) return i;
      i = i + 2'd1;
    end
    return start;
  endfunction

  function automatic logic [1:0] exp_base();
    return (m_valid && l2.nack_in != 4'd0) ? m_owner : m_rr;
  endfunction

  function automatic logic [3:0] exp_grant();
    if (m_cycle == 3'd7 && l2.req != 4'd0) return 4'b0001 << pick(l2.req, exp_base());
    return 4'b0000;
  endfunction

  function automatic vec_t exp_vec();
    return {exp_grant(), m_cycle, m_valid, m_owner,
            m_valid ? cmd_a[m_owner]  : 3'd0,
            m_valid ? tag_a[m_owner]  : 5'd0,
            m_valid ? addr_a[m_owner] : 26'd0,
            m_valid ? data_a[m_owner] : 64'd0,
            m_valid && (l2.nack_in != 4'd0)};
  endfunction

  function automatic vec_t act_vec();
    return {l2.grant, l2.bus_cycle, l2.bus_valid, l2.bus_owner, l2.bus_cmd,
            l2.bus_tag, l2.bus_addr, l2.bus_data, l2.bus_nack};
  endfunction

  task automatic drive_fields();
    l2.req_cmd  = {cmd_a[3], cmd_a[2], cmd_a[1], cmd_a[0]};
    l2.req_tag  = {tag_a[3], tag_a[2], tag_a[1], tag_a[0]};
    l2.req_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
    l2.req_data = {data_a[3], data_a[2], data_a[1], data_a[0]};
  endtask

  task automatic new_data();
    foreach (data_a[i]) data_a[i] = {$urandom, $urandom};
    drive_fields();
  endtask

  task automatic new_fields();
    foreach (cmd_a[i]) begin
      cmd_a[i]  = 3'($urandom);
      tag_a[i]  = 5'($urandom);
      addr_a[i] = 26'($urandom);
    end
    new_data();
  endtask

  // Advance one clock; the model applies the slot rules to the inputs seen at the edge.
  task automatic tick();
    logic       any;
    logic [1:0] w;
    any = (l2.req != 4'd0);
    w   = pick(l2.req, exp_base());
    @(posedge clk);
    #1;
    if (m_cycle == 3'd7) begin
      m_valid = any;
      if (any) begin
        m_owner = w;
        m_rr    = 2'((int'(w) + 1) % 4);
      end
    end
    m_cycle = m_cycle + 3'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_cycle = 3'd0; m_valid = 1'b0; m_owner = 2'd0; m_rr = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    l2.req = 4'd0;
    l2.nack_in = 4'd0;
    new_fields();
    #1 rst = 1'b1;
    #2;
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs act=%h exp=0", act_vec());
    end
    do_reset();
    for (int n = 0; n < 10; n++) begin
      #1;
      vectors++;
      if (l2.bus_cycle !== 3'(n % 8) || l2.grant !== 4'd0 || l2.bus_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_count n=%0d cyc=%0d grant=%b valid=%b exp cyc=%0d grant=0 valid=0",
                 n, l2.bus_cycle, l2.grant, l2.bus_valid, n % 8);
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single_request();
    l2.req = 4'd0;
    for (int n = 0; n < 8 && m_cycle != 3'd3; n++) begin
      #1;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_idle_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
    l2.req = 4'b0010;
    cmd_a[1] = 3'd1;
    addr_a[1] = 26'h123;
    tag_a[1] = 5'($urandom);
    for (int n = 0; n < 5; n++) begin
      new_data();
      #1;
      vectors++;
      if (l2.grant !== ((m_cycle == 3'd7) ? 4'b0010 : 4'b0000)) begin
        miscompares++;
        $display("FAIL single_grant cyc=%0d grant=%b", m_cycle, l2.grant);
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_req_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
    l2.req = 4'd0;
    for (int n = 0; n < 8; n++) begin
      new_data();
      #1;
      vectors++;
      if (l2.bus_valid !== 1'b1 || l2.bus_owner !== 2'd1 || l2.bus_addr !== 26'h123 ||
          l2.bus_cmd !== 3'd1 || l2.bus_data !== data_a[1]) begin
        miscompares++;
        $display("FAIL single_slot beat=%0d valid=%b owner=%0d addr=%h cmd=%0d data=%h exp 1/1/123/1/%h",
                 n, l2.bus_valid, l2.bus_owner, l2.bus_addr, l2.bus_cmd, l2.bus_data, data_a[1]);
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_slot_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int slot = 0;
    do_reset();
    l2.req = 4'hF;
    for (int n = 0; n < 40; n++) begin
      new_data();
      #1;
      if (m_cycle == 3'd7 && slot < 5) begin
        vectors++;
        if (l2.grant !== (4'b0001 << order[slot]) || $countones(l2.grant) != 1) begin
          miscompares++;
          $display("FAIL rr_order slot=%0d grant=%b exp=%b", slot, l2.grant, 4'b0001 << order[slot]);
        end
        slot++;
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_nack_retry();
    do_reset();
    l2.req = 4'b0100;
    for (int n = 0; n < 8; n++) begin
      #1;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL nack_setup_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
    l2.req = 4'b1110;
    for (int n = 0; n < 16; n++) begin
      l2.nack_in = (n == 7) ? 4'b0100 : 4'b0000;
      #1;
      if (n == 0 || n == 8) begin
        vectors++;
        if (l2.bus_owner !== 2'd2) begin
          miscompares++;
          $display("FAIL nack_owner n=%0d owner=%0d exp=2", n, l2.bus_owner);
        end
      end
      if (n == 7) begin
        vectors++;
        if (l2.bus_nack !== 1'b1 || l2.grant !== 4'b0100) begin
          miscompares++;
          $display("FAIL nack_retry nack=%b grant=%b exp 1/0100", l2.bus_nack, l2.grant);
        end
      end
      if (n == 15) begin
        vectors++;
        if (l2.bus_nack !== 1'b0 || l2.grant !== 4'b1000) begin
          miscompares++;
          $display("FAIL nack_after nack=%b grant=%b exp 0/1000", l2.bus_nack, l2.grant);
        end
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL nack_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
    l2.nack_in = 4'd0;
    #1;
    vectors++;
    if (l2.bus_owner !== 2'd3) begin
      miscompares++;
      $display("FAIL nack_next_owner owner=%0d exp=3", l2.bus_owner);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    l2.req = 4'hF;
    for (int n = 0; n < 16 && !(m_valid && m_cycle == 3'd4); n++) begin
      #1;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL midrst_setup_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (l2.bus_valid !== 1'b0 || l2.grant !== 4'd0 || l2.bus_cycle !== 3'd0 || act_vec() !== '0) begin
      miscompares++;
      $display("FAIL midrst_async valid=%b grant=%b cyc=%0d all=%h exp all 0",
               l2.bus_valid, l2.grant, l2.bus_cycle, act_vec());
    end
    m_cycle = 3'd0; m_valid = 1'b0; m_owner = 2'd0; m_rr = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      vectors++;
      if (l2.grant !== ((n == 7) ? 4'b0001 : 4'b0000) || l2.bus_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_regrant n=%0d grant=%b valid=%b", n, l2.grant, l2.bus_valid);
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL midrst_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    l2.req = 4'b1000;
    for (int n = 0; n < 32; n++) begin
      new_data();
      #1;
      if (m_cycle == 3'd7) begin
        vectors++;
        if (l2.grant !== 4'b1000) begin
          miscompares++;
          $display("FAIL b2b_grant grant=%b exp=1000", l2.grant);
        end
      end
      if (seen) begin
        vectors++;
        if (l2.bus_valid !== 1'b1 || l2.bus_owner !== 2'd3) begin
          miscompares++;
          $display("FAIL b2b_slot cyc=%0d valid=%b owner=%0d exp 1/3", m_cycle, l2.bus_valid, l2.bus_owner);
        end
      end
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_vec cyc=%0d act=%h exp=%h", m_cycle, act_vec(), exp_vec());
      end
      if (m_cycle == 3'd7) seen = 1'b1;
      tick();
    end
    l2.req = 4'hF;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (m_cycle == 3'd7) begin
        vectors++;
        if (l2.grant !== 4'b0001) begin
          miscompares++;
          $display("FAIL b2b_wrap grant=%b exp=0001", l2.grant);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 320; n++) begin
      l2.req = 4'($urandom);
      l2.nack_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      new_fields();
      #1;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_vec n=%0d cyc=%0d act=%h exp=%h", n, m_cycle, act_vec(), exp_vec());
      end
      tick();
    end
    l2.nack_in = 4'd0;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_nack_retry();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
